crypto_engine_router: RTL and testbench
=======================================

// Module: crypto_engine_router
// PURPOSE
//  Parametrised successor of the dual-datapath top: steers one AAD/payload/tag session to one of N_ENG
//  crypto engines (AES-GCM, ChaCha20-Poly1305, ...). The engine is selected per session.
//  Exactly one engine sees valid/ready at a time, so there are no shared ready drivers.
//  Checks streamed byte counts against the programmed lengths. Sits between the stream ports and the engine cores.
// PARAMETERS
//  N_ENG  2    number of engines attached (>=2)
//  DW     128  stream data width, bits
//  KW     16   keep width, bytes (= DW/8)
//  LENW   64   length CSR width, bits
//  SELW   1    engine-select width (= $clog2(N_ENG))
// PORTS
//  clk            in   1          clock
//  rst            in   1          asynchronous active-high reset
//  start          in   1          session start pulse
//  abort          in   1          abandon the current session
//  eng_sel        in   SELW       engine for the session, sampled on start
//  len_aad_bits   in   LENW       AAD length, bits; sampled on start
//  len_pld_bits   in   LENW       payload length, bits; sampled on start
//  busy           out  1          session in progress
//  done           out  1          1-cycle pulse at session end
//  err_len        out  1          sticky: byte count != programmed length; cleared on start
//  err_sel        out  1          1-cycle pulse: eng_sel >= N_ENG at start
//  aad_valid/aad_ready/aad_last  in/out/in  1   upstream AAD handshake
//  aad_data/aad_keep             in    DW/KW  AAD beat
//  din_valid/din_ready/din_last  in/out/in  1   upstream payload-in handshake
//  din_data/din_keep             in    DW/KW  payload-in beat
//  dout_valid/dout_ready/dout_last  out/in/out  1  payload-out handshake
//  dout_data/dout_keep           out   DW/KW  payload-out beat
//  tag_out        out  128        tag captured from the selected engine
//  tag_out_valid  out  1          1-cycle pulse
//  e_start/e_abort  out  N_ENG    per-engine one-hot pulses
//  e_aad_valid/e_aad_ready    out/in  N_ENG    per-engine AAD handshake; data/keep/last fan out unmuxed
//  e_din_valid/e_din_ready    out/in  N_ENG    per-engine payload-in handshake; data/keep/last fan out unmuxed
//  e_dout_valid/e_dout_ready  in/out  N_ENG    per-engine payload-out handshake
//  e_dout_data/keep/last      in   N_ENG*DW / N_ENG*KW / N_ENG   flattened, engine i at slice i
//  e_tag/e_tag_valid          in   N_ENG*128 / N_ENG             per-engine tag
// BEHAVIOUR
//  Reset: state=IDLE, sel_q=0, counters=0, tag_out=0. All outputs 0, including every ready and e_* valid.
//  FSM IDLE->AAD->PLD->TAG->IDLE.
//   IDLE, start with eng_sel<N_ENG: latch sel/lengths, clear err_len, pulse e_start[sel] (1 cycle).
//     Next state: AAD if len_aad!=0, else PLD if len_pld!=0, else TAG.
//   IDLE, start with eng_sel>=N_ENG: err_sel pulse only; stay in IDLE.
//   start while busy: ignored.
//  Muxing is combinational with zero latency and no skid. In AAD: e_aad_valid[sel]=aad_valid, aad_ready=e_aad_ready[sel].
//   In PLD: din and dout are forwarded the same way through sel. All non-selected lanes are 0.
//  Byte counters add popcount(keep) on each handshake. Keep must be contiguous from LSB; holes are counted as-is.
//   AAD->PLD (or TAG) on aad handshake with aad_last; err_len set if aad_cnt*8 != len_aad.
//   PLD->TAG on dout handshake with dout_last; err_len set if din_cnt*8 != len_pld or dout_cnt != din_cnt.
//   din_last is forwarded only. Ingress may finish before egress.
//  TAG: first cycle with e_tag_valid[sel] -> register tag_out, pulse tag_out_valid and done next cycle, go IDLE.
//   e_tag_valid from other engines is ignored in every state.
//  abort (priority over everything, any state != IDLE): pulse e_abort[sel], drop readies and valids same cycle,
//   go IDLE next cycle, no done, err_len kept. abort in IDLE: no effect.
//  start together with the last TAG cycle: ignored, because busy is still 1.
//  Counters are LENW-3 bits wide and wrap silently; overflow is caught by the length compare.
//  Async reset mid-session: everything returns to reset values immediately; engines are not aborted.
// STRUCTURE
//  Package crypto_rt_pkg: state enum, DW/KW/LENW defaults, function popcount_keep().
//  Sub-module crypto_rt_lane_mux: one N_ENG->1 valid/ready/data mux, instantiated for AAD, din and dout.
// TESTING
//  sel=1, len_aad=128, len_pld=256, 1 AAD + 2 din beats full keep -> e_*[1] only; done; err_len=0.
//  len_aad=40 (5 B), AAD keep=16'h001F, last -> no err; repeat with keep=16'h00FF -> err_len=1.
//  len_aad=0, len_pld=0 -> IDLE->TAG directly; e_tag_valid[0]=1 with tag=128'hA5.. -> tag_out_valid, done.
//  eng_sel=N_ENG -> err_sel=1 for 1 cycle, busy stays 0, no e_start.
//  abort mid-PLD with dout_ready=0 stalls -> e_abort[sel] pulse, all readies 0 next cycle, IDLE, no done.
//  Random valid/ready back-pressure on both sides, 64 beats -> dout data matches engine stream, in order, lossless.

Source files
------------

// File: rtl/crypto_rt_pkg.sv
// -----------------------------------------------------------------------------
// crypto_rt_pkg
// Shared types and helpers for the crypto engine router: session state
// encoding, default stream/length widths and the keep popcount used by the
// byte counters.
// -----------------------------------------------------------------------------
package crypto_rt_pkg;

    localparam int DEF_DW   = 128;
    localparam int DEF_KW   = 16;
    localparam int DEF_LENW = 64;
    localparam int TAG_W    = 128;

    // Widest keep the popcount helper accepts; narrower keeps are zero-extended.
    localparam int KW_MAX   = 64;
    localparam int PCW      = $clog2(KW_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AAD,
        ST_PLD,
        ST_TAG
    } state_e;

    // Number of set keep bits. Holes are counted as-is; a non-contiguous keep
    // shows up later as a length mismatch rather than being rejected here.
    function automatic logic [PCW-1:0] popcount_keep(input logic [KW_MAX-1:0] keep);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < KW_MAX; i++) begin
            n = n + PCW'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/crypto_engine_router_if.sv
// -----------------------------------------------------------------------------
// crypto_engine_router_if
// Upstream-facing stream bundle of the router: AAD in, payload in, payload out.
//   master : the stream source/sink outside the router (drives AAD/din, sinks dout)
//   slave  : the router itself
// -----------------------------------------------------------------------------
interface crypto_engine_router_if
    import crypto_rt_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int KW = DEF_KW
) ();

    logic          aad_valid;
    logic          aad_ready;
    logic          aad_last;
    logic [DW-1:0] aad_data;
    logic [KW-1:0] aad_keep;

    logic          din_valid;
    logic          din_ready;
    logic          din_last;
    logic [DW-1:0] din_data;
    logic [KW-1:0] din_keep;

    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic [DW-1:0] dout_data;
    logic [KW-1:0] dout_keep;

    modport master (
        output aad_valid, aad_last, aad_data, aad_keep,
        output din_valid, din_last, din_data, din_keep,
        output dout_ready,
        input  aad_ready, din_ready,
        input  dout_valid, dout_last, dout_data, dout_keep
    );

    modport slave (
        input  aad_valid, aad_last, aad_data, aad_keep,
        input  din_valid, din_last, din_data, din_keep,
        input  dout_ready,
        output aad_ready, din_ready,
        output dout_valid, dout_last, dout_data, dout_keep
    );

endinterface

// File: rtl/crypto_rt_lane_mux.sv
// -----------------------------------------------------------------------------
// crypto_rt_lane_mux
// One N->1 handshake lane. A scalar signal on the single side (one_in) is
// steered to engine `sel` only (many_out), and a W-bit slice from engine `sel`
// (many_in) is returned on the single side (one_out). Everything is 0 when
// en is low. Purely combinational: zero latency, no skid buffer.
//   en       in   lane enable (state match and no abort)
//   sel      in   selected engine
//   one_in   in   valid (ingress lanes) or ready (egress lane) from the port side
//   many_out out  per-engine copy of one_in, one-hot
//   many_in  in   per-engine W-bit slices (ready, or valid/last/keep/data)
//   one_out  out  slice of the selected engine
// -----------------------------------------------------------------------------
module crypto_rt_lane_mux #(
    parameter int N    = 2,
    parameter int SELW = 1,
    parameter int W    = 1
) (
    input  logic              en,
    input  logic [SELW-1:0]   sel,
    input  logic              one_in,
    output logic [N-1:0]      many_out,
    input  logic [N*W-1:0]    many_in,
    output logic [W-1:0]      one_out
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path through
        // the block leaves a value held and no latch is inferred.
        many_out = '0;
        one_out  = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (sel == SELW'(i))) begin
                many_out[i] = one_in;
                one_out     = many_in[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/crypto_engine_router.sv
// -----------------------------------------------------------------------------
// crypto_engine_router
// Steers one AAD/payload/tag session to one of N_ENG crypto engines chosen at
// start, and checks streamed byte counts against the programmed bit lengths.
// Only the selected engine ever sees valid/ready; all other lanes read 0.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   start, abort, eng_sel        session control (eng_sel sampled on start)
//   len_aad_bits, len_pld_bits   programmed lengths in bits, sampled on start
//   busy, done, err_len, err_sel session status
//   s                            upstream AAD / payload-in / payload-out streams
//   tag_out, tag_out_valid       tag captured from the selected engine
//   e_start, e_abort             per-engine one-hot pulses
//   e_aad_*, e_din_*, e_dout_*   per-engine stream handshakes (ingress data fans out)
//   e_tag, e_tag_valid           per-engine tag, engine i at slice i
// -----------------------------------------------------------------------------
module crypto_engine_router
    import crypto_rt_pkg::*;
#(
    parameter int N_ENG = 2,
    parameter int DW    = DEF_DW,
    parameter int KW    = DEF_KW,
    parameter int LENW  = DEF_LENW,
    parameter int SELW  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [SELW-1:0]        eng_sel,
    input  logic [LENW-1:0]        len_aad_bits,
    input  logic [LENW-1:0]        len_pld_bits,
    output logic                   busy,
    output logic                   done,
    output logic                   err_len,
    output logic                   err_sel,
    crypto_engine_router_if.slave  s,
    output logic [TAG_W-1:0]       tag_out,
    output logic                   tag_out_valid,
    output logic [N_ENG-1:0]       e_start,
    output logic [N_ENG-1:0]       e_abort,
    output logic [N_ENG-1:0]       e_aad_valid,
    input  logic [N_ENG-1:0]       e_aad_ready,
    output logic [DW-1:0]          e_aad_data,
    output logic [KW-1:0]          e_aad_keep,
    output logic                   e_aad_last,
    output logic [N_ENG-1:0]       e_din_valid,
    input  logic [N_ENG-1:0]       e_din_ready,
    output logic [DW-1:0]          e_din_data,
    output logic [KW-1:0]          e_din_keep,
    output logic                   e_din_last,
    input  logic [N_ENG-1:0]       e_dout_valid,
    output logic [N_ENG-1:0]       e_dout_ready,
    input  logic [N_ENG*DW-1:0]    e_dout_data,
    input  logic [N_ENG*KW-1:0]    e_dout_keep,
    input  logic [N_ENG-1:0]       e_dout_last,
    input  logic [N_ENG*TAG_W-1:0] e_tag,
    input  logic [N_ENG-1:0]       e_tag_valid
);

    localparam int CW = LENW - 3;    // byte counters; bit length = count * 8
    localparam int PW = DW + KW + 2; // egress bundle {valid, last, keep, data}

    function automatic logic [N_ENG-1:0] onehot(input logic [SELW-1:0] idx);
        logic [N_ENG-1:0] v;
        v = '0;
        for (int i = 0; i < N_ENG; i++) begin
            v[i] = (idx == SELW'(i));
        end
        return v;
    endfunction

    function automatic logic [CW-1:0] keep_bytes(input logic [KW-1:0] keep);
        return CW'(popcount_keep(KW_MAX'(keep)));
    endfunction

    state_e            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [LENW-1:0]   len_aad_q, len_aad_d, len_pld_q, len_pld_d;
    logic [CW-1:0]     aad_cnt_q, aad_cnt_d, din_cnt_q, din_cnt_d, dout_cnt_q, dout_cnt_d;
    logic              err_len_q, err_len_d;
    logic              done_q, done_d;
    logic [TAG_W-1:0]  tag_out_q, tag_out_d;
    logic              tag_valid_q, tag_valid_d;

    logic              aad_en, pld_en, aad_ready, din_ready;
    logic              aad_hs, din_hs, dout_hs;
    logic [N_ENG*PW-1:0] dout_bundle;
    logic [PW-1:0]     dout_out;
    logic [TAG_W-1:0]  sel_tag;
    logic              sel_tag_valid;
    logic              sel_ok;

    // Abort drops every lane in the same cycle it is raised.
    assign aad_en = (state_q == ST_AAD) && !abort;
    assign pld_en = (state_q == ST_PLD) && !abort;

    // Ingress data/keep/last go to all engines; only valid is steered.
    assign e_aad_data = s.aad_data;
    assign e_aad_keep = s.aad_keep;
    assign e_aad_last = s.aad_last;
    assign e_din_data = s.din_data;
    assign e_din_keep = s.din_keep;
    assign e_din_last = s.din_last;

    crypto_rt_lane_mux #(.N(N_ENG), .SELW(SELW), .W(1)) u_aad_mux (
        .en(aad_en), .sel(sel_q), .one_in(s.aad_valid),
        .many_out(e_aad_valid), .many_in(e_aad_ready), .one_out(aad_ready)
    );

    crypto_rt_lane_mux #(.N(N_ENG), .SELW(SELW), .W(1)) u_din_mux (
        .en(pld_en), .sel(sel_q), .one_in(s.din_valid),
        .many_out(e_din_valid), .many_in(e_din_ready), .one_out(din_ready)
    );

    for (genvar g = 0; g < N_ENG; g++) begin : g_dout_pack
        assign dout_bundle[g*PW +: PW] = {e_dout_valid[g], e_dout_last[g],
                                          e_dout_keep[g*KW +: KW], e_dout_data[g*DW +: DW]};
    end

    crypto_rt_lane_mux #(.N(N_ENG), .SELW(SELW), .W(PW)) u_dout_mux (
        .en(pld_en), .sel(sel_q), .one_in(s.dout_ready),
        .many_out(e_dout_ready), .many_in(dout_bundle), .one_out(dout_out)
    );

    assign s.aad_ready = aad_ready;
    assign s.din_ready = din_ready;
    assign {s.dout_valid, s.dout_last, s.dout_keep, s.dout_data} = dout_out;

    assign aad_hs  = s.aad_valid && aad_ready;
    assign din_hs  = s.din_valid && din_ready;
    assign dout_hs = dout_out[PW-1] && s.dout_ready;

    // Tag lane of the session engine; other engines' tag_valid never matters.
    always_comb begin
        sel_tag       = '0;
        sel_tag_valid = 1'b0;
        for (int i = 0; i < N_ENG; i++) begin
            if (sel_q == SELW'(i)) begin
                sel_tag       = e_tag[i*TAG_W +: TAG_W];
                sel_tag_valid = e_tag_valid[i];
            end
        end
    end

    assign sel_ok = ({1'b0, eng_sel} < (SELW+1)'(N_ENG));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        len_aad_d   = len_aad_q;
        len_pld_d   = len_pld_q;
        aad_cnt_d   = aad_cnt_q;
        din_cnt_d   = din_cnt_q;
        dout_cnt_d  = dout_cnt_q;
        err_len_d   = err_len_q;
        tag_out_d   = tag_out_q;
        done_d      = 1'b0;
        tag_valid_d = 1'b0;
        e_start     = '0;
        e_abort     = '0;
        err_sel     = 1'b0;

        if (abort && state_q != ST_IDLE) begin
            e_abort = onehot(sel_q);
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && sel_ok) begin
                        sel_d      = eng_sel;
                        len_aad_d  = len_aad_bits;
                        len_pld_d  = len_pld_bits;
                        aad_cnt_d  = '0;
                        din_cnt_d  = '0;
                        dout_cnt_d = '0;
                        err_len_d  = 1'b0;
                        e_start    = onehot(eng_sel);
                        if (len_aad_bits != '0)      state_d = ST_AAD;
                        else if (len_pld_bits != '0) state_d = ST_PLD;
                        else                         state_d = ST_TAG;
                    end else if (start) begin
                        err_sel = 1'b1;
                    end
                end
                ST_AAD: begin
                    if (aad_hs) begin
                        aad_cnt_d = aad_cnt_q + keep_bytes(s.aad_keep);
                        if (s.aad_last) begin
                            // Compare includes the closing beat, hence the _d count.
                            if ({aad_cnt_d, 3'b000} != len_aad_q) err_len_d = 1'b1;
                            state_d = (len_pld_q != '0) ? ST_PLD : ST_TAG;
                        end
                    end
                end
                ST_PLD: begin
                    if (din_hs)  din_cnt_d  = din_cnt_q  + keep_bytes(s.din_keep);
                    if (dout_hs) dout_cnt_d = dout_cnt_q + keep_bytes(s.dout_keep);
                    // Only egress closes the phase; din_last is just forwarded.
                    if (dout_hs && s.dout_last) begin
                        if (({din_cnt_d, 3'b000} != len_pld_q) || (dout_cnt_d != din_cnt_d))
                            err_len_d = 1'b1;
                        state_d = ST_TAG;
                    end
                end
                ST_TAG: begin
                    if (sel_tag_valid) begin
                        tag_out_d   = sel_tag;
                        tag_valid_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            len_aad_q   <= '0;
            len_pld_q   <= '0;
            aad_cnt_q   <= '0;
            din_cnt_q   <= '0;
            dout_cnt_q  <= '0;
            err_len_q   <= 1'b0;
            done_q      <= 1'b0;
            tag_out_q   <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            len_aad_q   <= len_aad_d;
            len_pld_q   <= len_pld_d;
            aad_cnt_q   <= aad_cnt_d;
            din_cnt_q   <= din_cnt_d;
            dout_cnt_q  <= dout_cnt_d;
            err_len_q   <= err_len_d;
            done_q      <= done_d;
            tag_out_q   <= tag_out_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign err_len       = err_len_q;
    assign tag_out       = tag_out_q;
    assign tag_out_valid = tag_valid_q;

endmodule

// File: tb/tb_crypto_engine_router.sv
// -----------------------------------------------------------------------------
// tb_crypto_engine_router
// Directed bench for the router with three engines (so an out-of-range select
// exists), plus a back-pressured 64-beat payload run checked by beat index.
// -----------------------------------------------------------------------------
module tb_crypto_engine_router;
    import crypto_rt_pkg::*;

    localparam int N_ENG = 3;
    localparam int DW    = 128;
    localparam int KW    = 16;
    localparam int LENW  = 64;
    localparam int SELW  = 2;
    localparam int NBEAT = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start, abort;
    logic [SELW-1:0]        eng_sel;
    logic [LENW-1:0]        len_aad_bits, len_pld_bits;
    logic                   busy, done, err_len, err_sel;
    logic [TAG_W-1:0]       tag_out;
    logic                   tag_out_valid;
    logic [N_ENG-1:0]       e_start, e_abort;
    logic [N_ENG-1:0]       e_aad_valid, e_aad_ready;
    logic [DW-1:0]          e_aad_data;
    logic [KW-1:0]          e_aad_keep;
    logic                   e_aad_last;
    logic [N_ENG-1:0]       e_din_valid, e_din_ready;
    logic [DW-1:0]          e_din_data;
    logic [KW-1:0]          e_din_keep;
    logic                   e_din_last;
    logic [N_ENG-1:0]       e_dout_valid, e_dout_ready;
    logic [N_ENG*DW-1:0]    e_dout_data;
    logic [N_ENG*KW-1:0]    e_dout_keep;
    logic [N_ENG-1:0]       e_dout_last;
    logic [N_ENG*TAG_W-1:0] e_tag;
    logic [N_ENG-1:0]       e_tag_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    crypto_engine_router_if #(.DW(DW), .KW(KW)) s_if ();

    crypto_engine_router #(
        .N_ENG(N_ENG), .DW(DW), .KW(KW), .LENW(LENW), .SELW(SELW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .eng_sel(eng_sel),
        .len_aad_bits(len_aad_bits), .len_pld_bits(len_pld_bits),
        .busy(busy), .done(done), .err_len(err_len), .err_sel(err_sel),
        .s(s_if),
        .tag_out(tag_out), .tag_out_valid(tag_out_valid),
        .e_start(e_start), .e_abort(e_abort),
        .e_aad_valid(e_aad_valid), .e_aad_ready(e_aad_ready),
        .e_aad_data(e_aad_data), .e_aad_keep(e_aad_keep), .e_aad_last(e_aad_last),
        .e_din_valid(e_din_valid), .e_din_ready(e_din_ready),
        .e_din_data(e_din_data), .e_din_keep(e_din_keep), .e_din_last(e_din_last),
        .e_dout_valid(e_dout_valid), .e_dout_ready(e_dout_ready),
        .e_dout_data(e_dout_data), .e_dout_keep(e_dout_keep), .e_dout_last(e_dout_last),
        .e_tag(e_tag), .e_tag_valid(e_tag_valid)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] beat_pat(input int k);
        return {32'hBEEF0000 + 32'(k), ~32'(k), 32'(k * 7), 32'h5A5A0000 ^ 32'(k)};
    endfunction

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; eng_sel = '0;
        len_aad_bits = '0; len_pld_bits = '0;
        s_if.aad_valid = 1'b0; s_if.aad_last = 1'b0; s_if.aad_data = '0; s_if.aad_keep = '0;
        s_if.din_valid = 1'b0; s_if.din_last = 1'b0; s_if.din_data = '0; s_if.din_keep = '0;
        s_if.dout_ready = 1'b0;
        e_aad_ready = '1; e_din_ready = '1;
        e_dout_valid = '0; e_dout_data = '0; e_dout_keep = '1; e_dout_last = '0;
        e_tag = '0; e_tag_valid = '0;
    endtask

    // Returns at the negedge after start was taken (state already advanced).
    task automatic start_session(input logic [SELW-1:0] sel, input logic [LENW-1:0] la,
                                 input logic [LENW-1:0] lp);
        logic [N_ENG-1:0] exp_oh;
        exp_oh = N_ENG'(1) << sel;
        @(negedge clk);
        start = 1'b1; eng_sel = sel; len_aad_bits = la; len_pld_bits = lp;
        #1;
        check("e_start", e_start, exp_oh);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    // Called at a negedge while in TAG; completes the session on engine `eng`.
    task automatic finish_tag(input int eng, input logic [127:0] tag, input logic exp_err);
        e_tag[eng*TAG_W +: TAG_W] = tag;
        e_tag_valid = N_ENG'(1) << eng;
        @(negedge clk);
        e_tag_valid = '0;
        check("tag_out_valid", tag_out_valid, 1'b1);
        check("done_pulse", done, 1'b1);
        check("tag_out", tag_out, tag);
        check("busy_after_tag", busy, 1'b0);
        check("err_len_end", err_len, exp_err);
    endtask

    int  tx_idx, rx_idx, up_din_cnt, eng_din_cnt;
    bit  eng_tx_hs, up_din_hs, eng_din_hs;

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        // Reset: every output quiet even with engines asserting ready.
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err_len", err_len, 1'b0);
        check("rst_tag_out", tag_out, 128'h0);
        check("rst_tag_valid", tag_out_valid, 1'b0);
        check("rst_e_dout_ready", e_dout_ready, 3'b000);
        check("rst_aad_ready", s_if.aad_ready, 1'b0);
        rst = 1'b0;

        // ---- Session 1: engine 1, 16 B AAD, 32 B payload ----
        start_session(2'd1, 64'd128, 64'd256);
        s_if.aad_valid = 1'b1; s_if.aad_keep = 16'hFFFF; s_if.aad_last = 1'b1;
        s_if.aad_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        #1;
        check("s1_e_aad_valid", e_aad_valid, 3'b010);
        check("s1_aad_ready", s_if.aad_ready, 1'b1);
        check("s1_e_aad_data", e_aad_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        check("s1_din_ready_in_aad", s_if.din_ready, 1'b0);
        @(negedge clk);
        s_if.aad_valid = 1'b0; s_if.aad_last = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s_if.din_valid = 1'b1; s_if.din_keep = 16'hFFFF; s_if.din_last = (b == 1);
            s_if.din_data = beat_pat(100 + b);
            e_dout_valid = 3'b011;
            e_dout_data[0 +: DW] = 128'hDEAD;
            e_dout_data[DW +: DW] = beat_pat(b);
            e_dout_last = (b == 1) ? 3'b011 : 3'b000;
            s_if.dout_ready = 1'b1;
            #1;
            check("s1_e_din_valid", e_din_valid, 3'b010);
            check("s1_din_ready", s_if.din_ready, 1'b1);
            check("s1_dout_valid", s_if.dout_valid, 1'b1);
            check("s1_dout_data", s_if.dout_data, beat_pat(b));
            check("s1_e_dout_ready", e_dout_ready, 3'b010);
            @(negedge clk);
        end
        s_if.din_valid = 1'b0; s_if.din_last = 1'b0;
        e_dout_valid = '0; e_dout_last = '0; s_if.dout_ready = 1'b0;
        check("s1_in_tag_busy", busy, 1'b1);
        // Tag from a non-selected engine must be ignored.
        e_tag[0 +: TAG_W] = 128'hBAD;
        e_tag_valid = 3'b001;
        @(negedge clk);
        e_tag_valid = '0;
        check("s1_foreign_tag_done", done, 1'b0);
        finish_tag(1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        @(negedge clk);
        check("s1_done_one_cycle", done, 1'b0);

        // ---- Session 2a: 5 B AAD, keep 001F, matches 40 bits ----
        start_session(2'd0, 64'd40, 64'd0);
        s_if.aad_valid = 1'b1; s_if.aad_keep = 16'h001F; s_if.aad_last = 1'b1;
        @(negedge clk);
        s_if.aad_valid = 1'b0; s_if.aad_last = 1'b0;
        check("s2a_err_len", err_len, 1'b0);
        finish_tag(0, 128'h2A, 1'b0);

        // ---- Session 2b: keep 00FF = 64 bits vs 40 programmed ----
        start_session(2'd0, 64'd40, 64'd0);
        s_if.aad_valid = 1'b1; s_if.aad_keep = 16'h00FF; s_if.aad_last = 1'b1;
        @(negedge clk);
        s_if.aad_valid = 1'b0; s_if.aad_last = 1'b0;
        check("s2b_err_len", err_len, 1'b1);
        finish_tag(0, 128'h2B, 1'b1);

        // ---- Session 3: zero lengths go straight to TAG; err_len cleared ----
        start_session(2'd0, 64'd0, 64'd0);
        check("s3_err_len_cleared", err_len, 1'b0);
        s_if.aad_valid = 1'b1;
        #1;
        check("s3_no_aad_lane", e_aad_valid, 3'b000);
        s_if.aad_valid = 1'b0;
        finish_tag(0, {16{8'hA5}}, 1'b0);

        // ---- Out-of-range engine select ----
        @(negedge clk);
        start = 1'b1; eng_sel = 2'd3;
        #1;
        check("sel_err_pulse", err_sel, 1'b1);
        check("sel_err_no_start", e_start, 3'b000);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("sel_err_cleared", err_sel, 1'b0);
        check("sel_err_idle", busy, 1'b0);

        // ---- Abort mid-payload while egress is stalled ----
        start_session(2'd2, 64'd0, 64'd256);
        s_if.din_valid = 1'b1; s_if.din_keep = 16'hFFFF;
        e_dout_valid = 3'b100; s_if.dout_ready = 1'b0;
        #1;
        check("ab_stall_e_dout_ready", e_dout_ready, 3'b000);
        check("ab_stall_dout_valid", s_if.dout_valid, 1'b1);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("ab_e_abort", e_abort, 3'b100);
        check("ab_din_ready_drop", s_if.din_ready, 1'b0);
        check("ab_dout_valid_drop", s_if.dout_valid, 1'b0);
        check("ab_e_din_valid_drop", e_din_valid, 3'b000);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("ab_idle", busy, 1'b0);
        check("ab_no_done", done, 1'b0);
        check("ab_din_ready_idle", s_if.din_ready, 1'b0);
        abort = 1'b1;
        #1;
        check("ab_in_idle_no_effect", e_abort, 3'b000);
        @(negedge clk);
        abort = 1'b0;
        idle_inputs();

        // ---- Random back-pressure, 64 payload beats through engine 1 ----
        start_session(2'd1, 64'd0, LENW'(NBEAT * KW * 8));
        tx_idx = 0; rx_idx = 0; up_din_cnt = 0; eng_din_cnt = 0;
        eng_tx_hs = 1'b0; up_din_hs = 1'b0; eng_din_hs = 1'b0;
        s_if.din_keep = 16'hFFFF;
        e_dout_data[0 +: DW] = 128'hF00D;
        for (int cyc = 0; cyc < 4000 && rx_idx < NBEAT; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (eng_tx_hs)  tx_idx++;
            if (up_din_hs)  up_din_cnt++;
            if (eng_din_hs) eng_din_cnt++;
            // Engine 1 emits beat k only after it received input beat k.
            if (!e_dout_valid[1] || eng_tx_hs) begin
                e_dout_valid[1] = (tx_idx < eng_din_cnt) && ($urandom_range(0, 3) != 0);
                e_dout_data[DW +: DW] = beat_pat(tx_idx);
                e_dout_last[1] = (tx_idx == NBEAT - 1);
            end
            e_dout_valid[0] = 1'b1;  // foreign engine chatter
            if (!s_if.din_valid || up_din_hs) begin
                s_if.din_valid = (up_din_cnt < NBEAT) && ($urandom_range(0, 2) != 0);
                s_if.din_data  = beat_pat(1000 + up_din_cnt);
                s_if.din_last  = (up_din_cnt == NBEAT - 1);
            end
            e_din_ready[1]  = ($urandom_range(0, 2) != 0);
            s_if.dout_ready = ($urandom_range(0, 1) != 0);
            #1;
            eng_tx_hs  = e_dout_valid[1] && e_dout_ready[1];
            up_din_hs  = s_if.din_valid && s_if.din_ready;
            eng_din_hs = e_din_valid[1] && e_din_ready[1];
            if (s_if.dout_valid && s_if.dout_ready) begin
                check("rnd_dout_data", s_if.dout_data, beat_pat(rx_idx));
                rx_idx++;
            end
        end
        @(negedge clk);
        if (up_din_hs)  up_din_cnt++;
        if (eng_din_hs) eng_din_cnt++;
        if (eng_tx_hs)  tx_idx++;
        idle_inputs();
        check("rnd_rx_beats", 128'(rx_idx), 128'(NBEAT));
        check("rnd_eng_tx_beats", 128'(tx_idx), 128'(NBEAT));
        check("rnd_eng_din_beats", 128'(eng_din_cnt), 128'(NBEAT));
        check("rnd_up_din_beats", 128'(up_din_cnt), 128'(NBEAT));
        finish_tag(1, 128'hC0FFEE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
